dht11_scheduler: RTL
====================

DHT11_SCHEDULER -- requirements
Module: dht11_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every other port SHALL follow the list below.
REQ-002 The block SHALL provide these parameters:
- CLK_FREQ, default 100_000_000, clock frequency in Hz.
- MIN_GAP_CYC, default 200_000_000, minimum number of cycles between sensor reads (2 s).
- TIMEOUT_CYC, default 10_000_000, watchdog for a single read (100 ms).
- MAX_RETRY, default 2, number of extra attempts after a failed read.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- req  in  2  req[i] high = requester i wants a measurement; held until its response.
- rsp_valid  out  1  one-cycle pulse: a response is present.
- rsp_id  out  1  index of the requester being answered.
- rsp_data  out  16  {temperature_integer, humidity_integer}.
- rsp_err  out  1  high = all attempts failed.
- sns_start  out  1  one-cycle pulse that starts the DHT11 reader.
- sns_ready  in  1  one-cycle pulse from the reader: its result is valid.
- sns_data  in  16  reader result, {temp, hum}.
- sns_err  in  1  reader checksum or protocol failure; qualified by sns_ready.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 States SHALL be IDLE, GAP_WAIT, START, BUSY and DONE, held in a registered state variable.
REQ-005 The gap counter SHALL clear on reset, on sns_ready accepted in BUSY, and on a timeout; otherwise it SHALL increment and saturate at MIN_GAP_CYC. gap_done = (count == MIN_GAP_CYC).
REQ-006 IDLE with any req bit high SHALL capture the granted id, clear the retry count, and go to GAP_WAIT, or go directly to START if gap_done.
REQ-007 Arbitration SHALL be round-robin: when req == 2'b11, the requester not granted last SHALL win; last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 GAP_WAIT SHALL go to START in the cycle after gap_done is observed.
REQ-009 sns_start SHALL be high for exactly the one cycle spent in START; the next state SHALL be BUSY.
REQ-010 BUSY SHALL count cycles from 0. Exits:
- sns_ready with sns_err = 0 -> DONE, success.
- sns_ready with sns_err = 1 -> failure.
- count == TIMEOUT_CYC - 1 without sns_ready -> failure.
REQ-011 If sns_ready and the timeout occur in the same cycle, sns_ready SHALL take precedence.
REQ-012 On failure with retry count < MAX_RETRY, the block SHALL increment the retry count and go to GAP_WAIT. Otherwise it SHALL go to DONE with error = 1.
REQ-013 On success, DONE SHALL load rsp_data from sns_data, captured in the sns_ready cycle, and set rsp_err = 0. On final failure it SHALL load rsp_data = 16'h0000 and rsp_err = 1.
REQ-014 rsp_valid SHALL pulse for the single DONE cycle, one cycle after the terminating event, and the next state SHALL be IDLE.
REQ-015 rsp_id, rsp_data and rsp_err SHALL hold their values until the next DONE.
REQ-016 sns_ready SHALL be ignored outside BUSY.
REQ-017 If a requester deasserts req mid-operation, the block SHALL still complete the operation and pulse rsp_valid; the block SHALL NOT abort.
REQ-018 Latency: req sampled in IDLE at cycle N with gap_done -> sns_start at N+1; sns_ready at cycle M -> rsp_valid at M+1.
REQ-019 Counter widths SHALL be $clog2 of their parameter + 1; the retry count SHALL be $clog2(MAX_RETRY+1).

Reset
REQ-020 Reset SHALL set:
- state = IDLE, all counters = 0, last_grant = 1.
- rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0.
- sns_start = 0, busy = 0.
REQ-021 Reset asserted in any state SHALL abandon the operation in the next cycle without emitting rsp_valid. The gap restart from 0 after reset SHALL guarantee the sensor's power-up delay.

Structure
REQ-022 Package dht11_pkg SHALL hold the sched_state_t enum and the default values of CLK_FREQ, MIN_GAP_CYC, TIMEOUT_CYC and MAX_RETRY, which the reader block shares.
REQ-023 The saturating gap counter SHALL be the sub-module dht11_interval_timer (ports clk, rst, clear, done); all other logic SHALL stay in dht11_scheduler.

Verification (MIN_GAP_CYC=100, TIMEOUT_CYC=50, MAX_RETRY=2)
REQ-024 Release reset, req=2'b01 at cycle 0 -> sns_start exactly once, at reset release + 101 cycles; busy high from cycle 1.
REQ-025 After the start, drive sns_ready with sns_data=16'h1A2D, sns_err=0 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=16'h1A2D, rsp_err=0; state IDLE.
REQ-026 req=2'b11 from IDLE after reset -> requester 0 served first; requester 1 served second, its sns_start ≥100 cycles after the first sns_ready.
REQ-027 Reader never responds -> 3 sns_start pulses, each 50 BUSY cycles apart plus a ≥100-cycle gap, then rsp_valid with rsp_err=1, rsp_data=16'h0000.
REQ-028 First sns_ready with sns_err=1, second with sns_data=16'h1520 -> one retry, rsp_err=0, rsp_data=16'h1520.
REQ-029 Reset in BUSY, then sns_ready -> all outputs at reset values; no rsp_valid; next sns_start ≥100 cycles later.

Source files
------------

// File: rtl/dht11_pkg.sv
// ============================================================================
//  Module      : dht11_pkg
//  Description : Shared state encoding and default timing for the DHT11
//                scheduler and reader blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dht11_pkg;

    localparam int c_clk_freq    = 100_000_000;
    localparam int c_min_gap_cyc = 200_000_000;
    localparam int c_timeout_cyc = 10_000_000;
    localparam int c_max_retry   = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GAP_WAIT = 3'd1,
        START    = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/dht11_interval_timer.sv
// ============================================================================
//  Module      : dht11_interval_timer
//  Description : Saturating cycle counter enforcing the minimum spacing
//                between DHT11 reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dht11_interval_timer
    import dht11_pkg::*;
#(
    parameter int MIN_GAP_CYC = c_min_gap_cyc
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    localparam int              c_cnt_w = $clog2(MIN_GAP_CYC) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MIN_GAP_CYC);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count != c_cnt_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/dht11_scheduler.sv
// ============================================================================
//  Module      : dht11_scheduler
//  Description : Arbitrates two measurement requesters onto one DHT11 reader,
//                enforcing read spacing, a per-read watchdog and retries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dht11_scheduler
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ    = c_clk_freq,
    parameter int MIN_GAP_CYC = c_min_gap_cyc,
    parameter int TIMEOUT_CYC = c_timeout_cyc,
    parameter int MAX_RETRY   = c_max_retry
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        sns_start,
    input  logic        sns_ready,
    input  logic [15:0] sns_data,
    input  logic        sns_err,
    output logic        busy
);

    localparam int c_to_w = $clog2(TIMEOUT_CYC) + 1;
    localparam int c_rt_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [c_rt_w-1:0] c_rt_max  = c_rt_w'(MAX_RETRY);

    // The reader's bit timing needs at least microsecond resolution.
    if (CLK_FREQ < 1_000_000) begin : g_clk_check
        $error("dht11_scheduler: CLK_FREQ below 1 MHz is not supported");
    end

    sched_state_t       r_state;
    sched_state_t       w_next;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [c_rt_w-1:0]  r_retry;
    logic               r_last_grant;
    logic               r_grant_id;
    logic               w_grant_id;
    logic               w_gap_done;
    logic               w_gap_clear;
    logic               w_ready;
    logic               w_timeout;
    logic               w_success;
    logic               w_fail;
    logic               w_retry_ok;

    dht11_interval_timer #(
        .MIN_GAP_CYC (MIN_GAP_CYC)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_gap_clear),
        .done  (w_gap_done)
    );

    // On a tie the requester not served last wins.
    assign w_grant_id  = (req == 2'b11) ? ~r_last_grant : req[1];

    assign w_ready     = (r_state == BUSY) && sns_ready;
    assign w_timeout   = (r_state == BUSY) && !sns_ready && (r_to_cnt == c_to_last);
    assign w_success   = w_ready && !sns_err;
    assign w_fail      = (w_ready && sns_err) || w_timeout;
    assign w_retry_ok  = (r_retry < c_rt_max);
    assign w_gap_clear = w_ready || w_timeout;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_next = w_gap_done ? START : GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                if (w_gap_done) begin
                    w_next = START;
                end
            end
            START: w_next = BUSY;
            BUSY: begin
                if (w_success) begin
                    w_next = DONE;
                end else if (w_fail) begin
                    w_next = w_retry_ok ? GAP_WAIT : DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt     <= '0;
            r_retry      <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= 16'h0000;
            rsp_err      <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == BUSY) ? r_to_cnt + 1'b1 : '0;

            if ((r_state == IDLE) && (|req)) begin
                r_grant_id   <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_retry      <= '0;
            end else if (w_fail && w_retry_ok) begin
                r_retry <= r_retry + 1'b1;
            end

            // Response fields change only on the edge that enters DONE.
            if (w_success) begin
                rsp_id   <= r_grant_id;
                rsp_data <= sns_data;
                rsp_err  <= 1'b0;
            end else if (w_fail && !w_retry_ok) begin
                rsp_id   <= r_grant_id;
                rsp_data <= 16'h0000;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign rsp_valid = (r_state == DONE);
    assign sns_start = (r_state == START);
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
